// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command engine.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_CMD,
    ST_POLL,
    ST_DATA,
    ST_FINISH
  } state_t;

  localparam logic [7:0] SD_CMD_START = 8'h40;
  localparam logic [7:0] SD_FILL      = 8'hFF;
  localparam logic [6:0] CRC7_POLY    = 7'h09;

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Host command handshake plus the byte-level link to the SPI shifter.
interface sd_cmd_engine_if;

  // host side
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;

  // shifter side
  logic        sd_cs_n;
  logic        spi_byte_valid;
  logic [7:0]  spi_byte_out;
  logic [7:0]  spi_byte_in;
  logic        spi_byte_ready;
  logic        spi_idle;

  // Environment view: host logic plus shifter.
  modport master (
    output cmd_start, cmd_index, cmd_arg, resp_long,
    output spi_byte_in, spi_byte_ready, spi_idle,
    input  busy, done, timeout, resp_r1, resp_data,
    input  sd_cs_n, spi_byte_valid, spi_byte_out
  );

  // Engine view.
  modport slave (
    input  cmd_start, cmd_index, cmd_arg, resp_long,
    input  spi_byte_in, spi_byte_ready, spi_idle,
    output busy, done, timeout, resp_r1, resp_data,
    output sd_cs_n, spi_byte_valid, spi_byte_out
  );

endinterface

// File: rtl/sd_crc7.sv
// Byte-wide CRC7 update (x^7 + x^3 + 1), data consumed MSB first.
module sd_crc7
  import sd_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data_in,
  output logic [6:0] crc_out
);

  logic [6:0] crc_v;
  logic       fb_v;

  // Unrolled bit-serial update over the eight data bits.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    crc_v = crc_in;
    fb_v  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      // NOTE: blocking assignments here so each bit step sees the previous step's
      // result; clocked state elsewhere uses non-blocking assignments.
      fb_v  = crc_v[6] ^ data_in[i];
      crc_v = {crc_v[5:0], 1'b0};
      if (fb_v) crc_v = crc_v ^ CRC7_POLY;
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// Frames one SD SPI-mode command, streams it into the byte shifter, polls for
// R1 within the NCR window and optionally captures four trailing response bytes.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 8,
  parameter int LEAD_FF = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  sd_cmd_engine_if.slave bus
);

  localparam logic [1:0] LEAD_LAST = 2'(LEAD_FF - 1);
  localparam logic [7:0] NCR_LAST  = 8'(NCR_MAX - 1);

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic [7:0]  r1_q;
  logic [31:0] data_q;
  logic        cs_n_q;
  logic        valid_q;
  logic [7:0]  out_q;
  logic        long_q;
  logic [1:0]  lead_cnt;
  logic [2:0]  byte_idx;
  logic [7:0]  poll_cnt;
  logic [1:0]  data_cnt;

  logic [7:0]  frame_in  [5];
  logic [6:0]  crc_chain [6];
  logic [7:0]  frame_q   [6];
  logic        accept;

  // Command bytes B0..B4 straight from the request, CRC chained across them.
  assign frame_in[0]  = SD_CMD_START | {2'b00, bus.cmd_index};
  assign frame_in[1]  = bus.cmd_arg[31:24];
  assign frame_in[2]  = bus.cmd_arg[23:16];
  assign frame_in[3]  = bus.cmd_arg[15:8];
  assign frame_in[4]  = bus.cmd_arg[7:0];
  assign crc_chain[0] = '0;

  for (genvar g = 0; g < 5; g++) begin : g_crc
    sd_crc7 u_crc (
      .crc_in  (crc_chain[g]),
      .data_in (frame_in[g]),
      .crc_out (crc_chain[g+1])
    );
  end

  // A start is taken only in IDLE and never in the done cycle.
  assign accept = (state_q == ST_IDLE) && !done_q && bus.cmd_start;

  // Capture the complete six-byte frame when a command is accepted.
  always_ff @(posedge clock) begin
    // NOTE: the frame store has no reset; it is always written on accept before
    // any byte of it is read, so resetting it would only add enable logic.
    if (accept) begin
      for (int i = 0; i < 5; i++) frame_q[i] <= frame_in[i];
      frame_q[5] <= {crc_chain[5], 1'b1};
    end
  end

  // Command sequencer with registered handshake and shifter outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      r1_q      <= SD_FILL;
      data_q    <= '0;
      cs_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      out_q     <= SD_FILL;
      long_q    <= 1'b0;
      lead_cnt  <= '0;
      byte_idx  <= '0;
      poll_cnt  <= '0;
      data_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (done_q) busy_q <= 1'b0;
          if (accept) begin
            busy_q    <= 1'b1;
            cs_n_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            r1_q      <= SD_FILL;
            data_q    <= '0;
            long_q    <= bus.resp_long;
            lead_cnt  <= '0;
            byte_idx  <= '0;
            if (LEAD_FF > 0) begin
              out_q   <= SD_FILL;
              state_q <= ST_LEAD;
            end else begin
              out_q   <= frame_in[0];
              state_q <= ST_CMD;
            end
          end
        end
        ST_LEAD: begin
          if (bus.spi_byte_ready) begin
            if (lead_cnt == LEAD_LAST) begin
              out_q    <= frame_q[0];
              byte_idx <= '0;
              state_q  <= ST_CMD;
            end else begin
              lead_cnt <= lead_cnt + 2'd1;
            end
          end
        end
        ST_CMD: begin
          if (bus.spi_byte_ready) begin
            if (byte_idx == 3'd5) begin
              out_q    <= SD_FILL;
              poll_cnt <= '0;
              state_q  <= ST_POLL;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              out_q    <= frame_q[byte_idx + 3'd1];
            end
          end
        end
        ST_POLL: begin
          if (bus.spi_byte_ready) begin
            if (!bus.spi_byte_in[7]) begin
              r1_q <= bus.spi_byte_in;
              if (long_q) begin
                data_cnt <= '0;
                state_q  <= ST_DATA;
              end else begin
                valid_q <= 1'b0;
                state_q <= ST_FINISH;
              end
            end else if (poll_cnt == NCR_LAST) begin
              timeout_q <= 1'b1;
              valid_q   <= 1'b0;
              state_q   <= ST_FINISH;
            end else begin
              poll_cnt <= poll_cnt + 8'd1;
            end
          end
        end
        ST_DATA: begin
          if (bus.spi_byte_ready) begin
            data_q <= {data_q[23:0], bus.spi_byte_in};
            if (data_cnt == 2'd3) begin
              valid_q <= 1'b0;
              state_q <= ST_FINISH;
            end else begin
              data_cnt <= data_cnt + 2'd1;
            end
          end
        end
        ST_FINISH: begin
          if (bus.spi_idle) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.resp_r1        = r1_q;
  assign bus.resp_data      = data_q;
  assign bus.sd_cs_n        = cs_n_q;
  assign bus.spi_byte_valid = valid_q;
  assign bus.spi_byte_out   = out_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench: sd_cmd_engine paired with a byte shifter and a scripted card.
module tb_sd_cmd_engine;

  localparam int NCR_MAX    = 8;
  localparam int LEAD_FF    = 1;
  localparam int FRAME_LEN  = LEAD_FF + 6;
  localparam int SCRIPT_LEN = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  sd_cmd_engine_if bus();

  sd_cmd_engine #(.NCR_MAX(NCR_MAX), .LEAD_FF(LEAD_FF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // card / shifter state
  logic [7:0] miso_script [SCRIPT_LEN];
  int         xfer_idx = 0;
  logic [7:0] mosi_q [$];

  // reference model state
  logic [7:0]  exp_mosi [$];
  logic [7:0]  nxt_r1 = 8'hFF, cur_r1 = 8'hFF;
  logic [31:0] nxt_data = '0, cur_data = '0;
  logic        nxt_to = 1'b0, cur_to = 1'b0;
  logic        prev_busy = 1'b0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Expected MOSI stream and result for a command against the current card script.
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic long_r);
    logic [39:0] msg;
    bit          found;
    int          p;
    msg = {2'b01, idx, arg};
    exp_mosi.delete();
    for (int i = 0; i < LEAD_FF; i++) exp_mosi.push_back(8'hFF);
    for (int i = 4; i >= 0; i--) exp_mosi.push_back(msg[i*8 +: 8]);
    exp_mosi.push_back({crc7_div(msg), 1'b1});
    nxt_r1   = 8'hFF;
    nxt_data = '0;
    nxt_to   = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < NCR_MAX && !found; k++) begin
      p = FRAME_LEN + k;
      exp_mosi.push_back(8'hFF);
      if (!miso_script[p][7]) begin
        found  = 1'b1;
        nxt_r1 = miso_script[p];
        nxt_to = 1'b0;
        if (long_r)
          for (int j = 1; j <= 4; j++) begin
            exp_mosi.push_back(8'hFF);
            nxt_data = {nxt_data[23:0], miso_script[p+j]};
          end
      end
    end
  endtask

  // Shifter plus card: one byte per valid, random length, card replies from the script.
  initial begin
    int   cnt;
    int   gap;
    logic active;
    cnt = 0; gap = 0; active = 1'b0;
    bus.spi_byte_ready = 1'b0;
    bus.spi_byte_in    = 8'hFF;
    bus.spi_idle       = 1'b1;
    forever begin
      @(negedge clock);
      bus.spi_byte_ready = 1'b0;
      if (!reset_n) begin
        active = 1'b0;
        gap = 0;
        bus.spi_idle = 1'b1;
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          bus.spi_byte_in    = (xfer_idx < SCRIPT_LEN) ? miso_script[xfer_idx] : 8'hFF;
          xfer_idx++;
          bus.spi_byte_ready = 1'b1;
          bus.spi_idle       = 1'b1;
          active = 1'b0;
          gap = $urandom_range(0, 2);
        end
      end else if (gap > 0) begin
        gap--;
      end else if (bus.spi_byte_valid) begin
        mosi_q.push_back(bus.spi_byte_out);
        active = 1'b1;
        cnt = $urandom_range(1, 4);
        bus.spi_idle = 1'b0;
      end
    end
  end

  // Per-cycle compare: held results, select and valid against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cur_r1 = 8'hFF; cur_data = '0; cur_to = 1'b0; prev_busy = 1'b0;
      end else begin
        if (bus.busy && !prev_busy) begin
          cur_r1 = nxt_r1; cur_data = nxt_data; cur_to = nxt_to;
        end
        prev_busy = bus.busy;
        if (bus.done) done_cnt++;
        if (!bus.busy || bus.done) begin
          check("resp_r1", bus.resp_r1, cur_r1);
          check("resp_data", bus.resp_data, cur_data);
          check("timeout", bus.timeout, cur_to);
          check("valid_low_idle", bus.spi_byte_valid, 1'b0);
          check("cs_high_idle", bus.sd_cs_n, 1'b1);
        end else begin
          check("cs_low_busy", bus.sd_cs_n, 1'b0);
        end
      end
    end
  end

  task automatic script_ff();
    for (int i = 0; i < SCRIPT_LEN; i++) miso_script[i] = 8'hFF;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic long_r);
    model_cmd(idx, arg, long_r);
    @(negedge clock);
    mosi_q.delete();
    xfer_idx = 0;
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_long = long_r;
    bus.cmd_start = 1'b1;
    @(negedge clock);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_mosi(input int n);
    for (int c = 0; c < 1000 && mosi_q.size() < n; c++) @(negedge clock);
    check("reach_byte", mosi_q.size() >= n, 1'b1);
  endtask

  // Full command: optional stray starts mid-command and in the done cycle.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic long_r,
                         input bit poke);
    int d0;
    bit ok;
    d0 = done_cnt;
    start_cmd(idx, arg, long_r);
    if (poke) begin
      wait_mosi(LEAD_FF + 2);
      bus.cmd_index = ~idx;
      bus.cmd_arg   = ~arg;
      bus.cmd_start = 1'b1;
      @(negedge clock);
      bus.cmd_start = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      if (bus.done) ok = 1'b1;
    end
    check("done_seen", ok, 1'b1);
    if (poke) begin
      bus.cmd_start = 1'b1;
      @(negedge clock);
      bus.cmd_start = 1'b0;
      check("busy_after_done_start", bus.busy, 1'b0);
      @(negedge clock);
      check("busy_stays_low", bus.busy, 1'b0);
    end
    repeat (3) @(negedge clock);
    check("single_done", done_cnt - d0, 1);
    check("mosi_len", mosi_q.size(), exp_mosi.size());
    for (int i = 0; i < exp_mosi.size() && i < mosi_q.size(); i++)
      check($sformatf("mosi[%0d]", i), mosi_q[i], exp_mosi[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [7:0] lit1 [9];
    bus.cmd_start = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_long = 1'b0;
    script_ff();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // reset state
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_timeout", bus.timeout, 1'b0);
    check("rst_r1", bus.resp_r1, 8'hFF);
    check("rst_data", bus.resp_data, 32'h0);
    check("rst_cs", bus.sd_cs_n, 1'b1);
    check("rst_valid", bus.spi_byte_valid, 1'b0);
    check("rst_out", bus.spi_byte_out, 8'hFF);

    // model pins: known CRC bytes
    check("crc_cmd0", {crc7_div(40'h40_0000_0000), 1'b1}, 8'h95);
    check("crc_cmd8", {crc7_div(40'h48_0000_01AA), 1'b1}, 8'h87);

    // 1: CMD0, R1=01 on 2nd fill byte
    script_ff();
    miso_script[FRAME_LEN + 1] = 8'h01;
    run_cmd(6'd0, 32'h0, 1'b0, 1'b0);
    lit1 = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
    check("t1_len", mosi_q.size(), 9);
    for (int i = 0; i < 9 && i < mosi_q.size(); i++)
      check($sformatf("t1_mosi[%0d]", i), mosi_q[i], lit1[i]);
    check("t1_r1", bus.resp_r1, 8'h01);
    check("t1_timeout", bus.timeout, 1'b0);

    // 2: CMD8 long response R7
    script_ff();
    miso_script[FRAME_LEN]     = 8'h01;
    miso_script[FRAME_LEN + 1] = 8'h00;
    miso_script[FRAME_LEN + 2] = 8'h00;
    miso_script[FRAME_LEN + 3] = 8'h01;
    miso_script[FRAME_LEN + 4] = 8'hAA;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
    if (mosi_q.size() > 6) check("t2_b5", mosi_q[6], 8'h87);
    else check("t2_b5_present", mosi_q.size(), 7);
    check("t2_r1", bus.resp_r1, 8'h01);
    check("t2_data", bus.resp_data, 32'h0000_01AA);

    // 3: CMD17, card silent -> NCR_MAX fill bytes then timeout
    script_ff();
    run_cmd(6'd17, 32'h0000_0200, 1'b0, 1'b0);
    check("t3_bytes", mosi_q.size(), 15);
    check("t3_timeout", bus.timeout, 1'b1);
    check("t3_r1", bus.resp_r1, 8'hFF);
    check("t3_cs", bus.sd_cs_n, 1'b1);

    // R1 on the last allowed fill byte still counts
    script_ff();
    miso_script[FRAME_LEN + NCR_MAX - 1] = 8'h00;
    run_cmd(6'd55, 32'h0, 1'b0, 1'b0);
    check("last_poll_timeout", bus.timeout, 1'b0);
    check("last_poll_r1", bus.resp_r1, 8'h00);

    // 4: stray starts during CMD and in the done cycle
    script_ff();
    miso_script[FRAME_LEN + 2] = 8'h00;
    run_cmd(6'd41, 32'h4000_0000, 1'b0, 1'b1);

    // 5: reset during POLL, then a clean CMD0
    script_ff();
    start_cmd(6'd17, 32'h1234_5678, 1'b0);
    wait_mosi(FRAME_LEN + 2);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(negedge clock);
    check("t5_cs", bus.sd_cs_n, 1'b1);
    check("t5_valid", bus.spi_byte_valid, 1'b0);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_done", bus.done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("t5_no_done", done_cnt - d0, 0);
    script_ff();
    miso_script[FRAME_LEN] = 8'h01;
    run_cmd(6'd0, 32'h0, 1'b0, 1'b0);
    check("t5_r1", bus.resp_r1, 8'h01);

    // 6: early 0x00 in the B3 slot is ignored
    script_ff();
    miso_script[LEAD_FF + 3] = 8'h00;
    miso_script[FRAME_LEN]   = 8'h05;
    run_cmd(6'd16, 32'h0000_0200, 1'b0, 1'b0);
    check("t6_r1", bus.resp_r1, 8'h05);

    // randomized commands and card behaviour
    for (int t = 0; t < 25; t++) begin
      int r1pos;
      for (int i = 0; i < SCRIPT_LEN; i++) miso_script[i] = 8'($urandom);
      r1pos = $urandom_range(0, NCR_MAX);
      for (int k = 0; k < NCR_MAX; k++) begin
        if (k < r1pos) miso_script[FRAME_LEN + k] = 8'($urandom) | 8'h80;
        else if (k == r1pos) miso_script[FRAME_LEN + k] = 8'($urandom) & 8'h7F;
      end
      run_cmd(6'($urandom), 32'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
